// File: rtl/dcache_uncached_port_if.sv
// Request/response and bus handshake bundle for the uncached data-cache port.
// The slave modport is the port block's view; master is the memory-stage/bus-model view.
interface dcache_uncached_port_if;
    logic        req_ce;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_sel;
    logic [31:0] req_data;
    logic [2:0]  req_rd_type;
    logic [2:0]  req_wr_type;

    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;

    logic        bus_rd_req;
    logic [2:0]  bus_rd_type;
    logic [31:0] bus_rd_addr;
    logic        bus_rd_rdy;
    logic        bus_ret_valid;
    logic [31:0] bus_ret_data;

    logic        bus_wr_req;
    logic [2:0]  bus_wr_type;
    logic [31:0] bus_wr_addr;
    logic [3:0]  bus_wr_strb;
    logic [31:0] bus_wr_data;
    logic        bus_wr_rdy;

    modport slave (
        input  req_ce, req_we, req_addr, req_sel, req_data, req_rd_type, req_wr_type,
        output ready_o, ack_o, rdata_o,
        output bus_rd_req, bus_rd_type, bus_rd_addr,
        input  bus_rd_rdy, bus_ret_valid, bus_ret_data,
        output bus_wr_req, bus_wr_type, bus_wr_addr, bus_wr_strb, bus_wr_data,
        input  bus_wr_rdy
    );

    modport master (
        output req_ce, req_we, req_addr, req_sel, req_data, req_rd_type, req_wr_type,
        input  ready_o, ack_o, rdata_o,
        input  bus_rd_req, bus_rd_type, bus_rd_addr,
        output bus_rd_rdy, bus_ret_valid, bus_ret_data,
        input  bus_wr_req, bus_wr_type, bus_wr_addr, bus_wr_strb, bus_wr_data,
        output bus_wr_rdy
    );
endinterface

// File: rtl/dcache_uncached_port.sv
// Uncached load/store port: turns one memory-stage request into a single bus read or write.
// Define DCACHE_UNCACHED_WBUF_EN to post stores through a 1-entry write buffer.
module dcache_uncached_port (
    input  logic                  clk,
    input  logic                  rst,
    dcache_uncached_port_if.slave cif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t      state_r;
    logic        ready_r;
    logic        ack_r;
    logic [31:0] rdata_r;
    logic        rd_req_r;
    logic [2:0]  rd_type_r;
    logic [31:0] rd_addr_r;
    logic        wr_req_r;
    logic [2:0]  wr_type_r;
    logic [31:0] wr_addr_r;
    logic [3:0]  wr_strb_r;
    logic [31:0] wr_data_r;
    logic        accept_s;

    // A request is taken only in the cycle the port advertises ready.
    always_comb begin
        accept_s = cif.req_ce & ready_r;
    end

`ifdef DCACHE_UNCACHED_WBUF_EN
    logic wbuf_empty_next_s;

    // The posted-write entry (held in the wr_* registers) frees up on its bus handshake.
    always_comb begin
        if (wr_req_r && !cif.bus_wr_rdy) begin
            wbuf_empty_next_s = 1'b0;
        end else begin
            wbuf_empty_next_s = 1'b1;
        end
    end
`endif

    // Main control FSM; all outputs are registered and bus fields only move on transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ready_r   <= 1'b1;
            ack_r     <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rd_req_r  <= 1'b0;
            rd_type_r <= 3'd0;
            rd_addr_r <= 32'h0000_0000;
            wr_req_r  <= 1'b0;
            wr_type_r <= 3'd0;
            wr_addr_r <= 32'h0000_0000;
            wr_strb_r <= 4'h0;
            wr_data_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ready_r <= 1'b0;
                        if (cif.req_we) begin
                            wr_req_r  <= 1'b1;
                            wr_addr_r <= cif.req_addr;
                            wr_strb_r <= cif.req_sel;
                            wr_data_r <= cif.req_data;
                            wr_type_r <= cif.req_wr_type;
`ifdef DCACHE_UNCACHED_WBUF_EN
                            ack_r     <= 1'b1;
                            state_r   <= RESP;
`else
                            state_r   <= WR_REQ;
`endif
                        end else begin
                            rd_req_r  <= 1'b1;
                            rd_addr_r <= cif.req_addr;
                            rd_type_r <= cif.req_rd_type;
                            state_r   <= RD_REQ;
                        end
                    end else begin
`ifdef DCACHE_UNCACHED_WBUF_EN
                        ready_r <= wbuf_empty_next_s;
`else
                        ready_r <= 1'b1;
`endif
                    end
                end
                RD_REQ: begin
                    // Return data arriving alongside the address handshake is not ours yet.
                    if (cif.bus_rd_rdy) begin
                        rd_req_r <= 1'b0;
                        state_r  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cif.bus_ret_valid) begin
                        rdata_r <= cif.bus_ret_data;
                        ack_r   <= 1'b1;
                        state_r <= RESP;
                    end
                end
                WR_REQ: begin
`ifdef DCACHE_UNCACHED_WBUF_EN
                    ready_r <= wbuf_empty_next_s;
                    state_r <= IDLE;
`else
                    if (cif.bus_wr_rdy) begin
                        wr_req_r <= 1'b0;
                        ack_r    <= 1'b1;
                        state_r  <= RESP;
                    end
`endif
                end
                RESP: begin
                    ack_r   <= 1'b0;
                    state_r <= IDLE;
`ifdef DCACHE_UNCACHED_WBUF_EN
                    ready_r <= wbuf_empty_next_s;
`else
                    ready_r <= 1'b1;
`endif
                end
                default: begin
                    ack_r    <= 1'b0;
                    ready_r  <= 1'b0;
                    rd_req_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
`ifdef DCACHE_UNCACHED_WBUF_EN
            // Buffer drain runs independently of the request FSM.
            if (wr_req_r && cif.bus_wr_rdy) begin
                wr_req_r <= 1'b0;
            end
`endif
        end
    end

    assign cif.ready_o     = ready_r;
    assign cif.ack_o       = ack_r;
    assign cif.rdata_o     = rdata_r;
    assign cif.bus_rd_req  = rd_req_r;
    assign cif.bus_rd_type = rd_type_r;
    assign cif.bus_rd_addr = rd_addr_r;
    assign cif.bus_wr_req  = wr_req_r;
    assign cif.bus_wr_type = wr_type_r;
    assign cif.bus_wr_addr = wr_addr_r;
    assign cif.bus_wr_strb = wr_strb_r;
    assign cif.bus_wr_data = wr_data_r;

endmodule

// File: tb/tb_dcache_uncached_port.sv
// Randomized bench for dcache_uncached_port: a transaction-level latency/data model plus
// a scripted bus responder; honours DCACHE_UNCACHED_WBUF_EN when defined.
module tb_dcache_uncached_port;

    logic clk = 1'b0;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [31:0] model_rdata;

    dcache_uncached_port_if cif ();

    dcache_uncached_port dut (
        .clk (clk),
        .rst (rst),
        .cif (cif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        cif.req_ce        = 1'b0;
        cif.req_we        = 1'b0;
        cif.req_addr      = 32'h0000_0000;
        cif.req_sel       = 4'h0;
        cif.req_data      = 32'h0000_0000;
        cif.req_rd_type   = 3'd0;
        cif.req_wr_type   = 3'd0;
        cif.bus_rd_rdy    = 1'b0;
        cif.bus_ret_valid = 1'b0;
        cif.bus_ret_data  = 32'h0000_0000;
        cif.bus_wr_rdy    = 1'b0;
    endtask

    // Garbage request presented while the port must be busy; it must never be taken.
    task automatic noise_request();
        logic [31:0] n;
        n = $urandom;
        cif.req_ce      = n[0];
        cif.req_we      = n[1];
        cif.req_addr    = $urandom;
        cif.req_sel     = n[7:4];
        cif.req_data    = $urandom;
        cif.req_rd_type = n[10:8];
        cif.req_wr_type = n[13:11];
    endtask

    // One request; r = extra cycles bus rdy stays low, w = extra cycles before return data.
    task automatic run_txn(input bit is_store, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, input logic [2:0] typ,
                           input int r, input int w, input logic [31:0] ret);
        int exp_ack;
        int exp_ready;
        logic [31:0] n;
        if (!is_store) begin
            exp_ack   = 3 + r + w;
            exp_ready = exp_ack + 1;
        end else begin
`ifdef DCACHE_UNCACHED_WBUF_EN
            exp_ack   = 1;
            exp_ready = 2 + r;
`else
            exp_ack   = 2 + r;
            exp_ready = 3 + r;
`endif
        end
        check_eq("ready_at_accept", 32'(cif.ready_o), 32'd1);
        idle_inputs();
        cif.req_ce      = 1'b1;
        cif.req_we      = is_store;
        cif.req_addr    = addr;
        cif.req_sel     = sel;
        cif.req_data    = data;
        cif.req_rd_type = typ;
        cif.req_wr_type = typ;
        for (int c = 1; c <= exp_ready; c++) begin
            @(negedge clk);
            if (!is_store && c == exp_ack) model_rdata = ret;
            check_eq("ack_o", 32'(cif.ack_o), 32'(c == exp_ack));
            check_eq("ready_o", 32'(cif.ready_o), 32'(c == exp_ready));
            check_eq("rdata_o", cif.rdata_o, model_rdata);
            check_eq("bus_rd_req", 32'(cif.bus_rd_req), 32'(!is_store && c <= 1 + r));
            check_eq("bus_wr_req", 32'(cif.bus_wr_req), 32'(is_store && c <= 1 + r));
            if (!is_store && c <= 1 + r) begin
                check_eq("bus_rd_addr", cif.bus_rd_addr, addr);
                check_eq("bus_rd_type", 32'(cif.bus_rd_type), 32'(typ));
            end
            if (is_store && c <= 1 + r) begin
                check_eq("bus_wr_addr", cif.bus_wr_addr, addr);
                check_eq("bus_wr_strb", 32'(cif.bus_wr_strb), 32'(sel));
                check_eq("bus_wr_data", cif.bus_wr_data, data);
                check_eq("bus_wr_type", 32'(cif.bus_wr_type), 32'(typ));
            end
            if (c < exp_ready) begin
                n = $urandom;
                noise_request();
                cif.bus_ret_data = $urandom;
                if (!is_store) begin
                    cif.bus_rd_rdy = (c == 1 + r) ? 1'b1 : ((c > 1 + r) ? n[1] : 1'b0);
                    if (c == 2 + r + w) begin
                        cif.bus_ret_valid = 1'b1;
                        cif.bus_ret_data  = ret;
                    end else if (c <= 1 + r || c > 2 + r + w) begin
                        cif.bus_ret_valid = n[2];
                    end else begin
                        cif.bus_ret_valid = 1'b0;
                    end
                    cif.bus_wr_rdy = n[3];
                end else begin
                    cif.bus_rd_rdy    = n[1];
                    cif.bus_ret_valid = n[2];
                    cif.bus_wr_rdy    = (c == 1 + r) ? 1'b1 : ((c > 1 + r) ? n[3] : 1'b0);
                end
            end else begin
                idle_inputs();
            end
        end
    endtask

    // Reset while waiting for read data: no ack, back to idle, late data ignored.
    task automatic reset_in_rd_wait();
        check_eq("rst_ready_at_accept", 32'(cif.ready_o), 32'd1);
        idle_inputs();
        cif.req_ce   = 1'b1;
        cif.req_addr = 32'h1fd0_0040;
        @(negedge clk);
        idle_inputs();
        cif.bus_rd_rdy = 1'b1;
        @(negedge clk);
        check_eq("rst_pre_rd_req", 32'(cif.bus_rd_req), 32'd0);
        check_eq("rst_pre_ack", 32'(cif.ack_o), 32'd0);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = 32'h0000_0000;
        check_eq("rst_ack", 32'(cif.ack_o), 32'd0);
        check_eq("rst_ready", 32'(cif.ready_o), 32'd1);
        check_eq("rst_rd_req", 32'(cif.bus_rd_req), 32'd0);
        check_eq("rst_rd_addr", cif.bus_rd_addr, 32'h0000_0000);
        check_eq("rst_rdata", cif.rdata_o, model_rdata);
        cif.bus_ret_valid = 1'b1;
        cif.bus_ret_data  = 32'h1234_5678;
        @(negedge clk);
        check_eq("late_ret_ack", 32'(cif.ack_o), 32'd0);
        check_eq("late_ret_rdata", cif.rdata_o, model_rdata);
        check_eq("late_ret_ready", 32'(cif.ready_o), 32'd1);
        idle_inputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_rdata = 32'h0000_0000;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", 32'(cif.ready_o), 32'd1);
        check_eq("reset_ack", 32'(cif.ack_o), 32'd0);
        check_eq("reset_rdata", cif.rdata_o, 32'h0000_0000);
        check_eq("reset_rd_req", 32'(cif.bus_rd_req), 32'd0);
        check_eq("reset_wr_req", 32'(cif.bus_wr_req), 32'd0);
        check_eq("reset_rd_addr", cif.bus_rd_addr, 32'h0000_0000);
        check_eq("reset_wr_addr", cif.bus_wr_addr, 32'h0000_0000);
        check_eq("reset_wr_data", cif.bus_wr_data, 32'h0000_0000);
        check_eq("reset_wr_strb", 32'(cif.bus_wr_strb), 32'd0);
        check_eq("reset_types", 32'({cif.bus_rd_type, cif.bus_wr_type}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 32'h1fd0_0004, 4'hf, 32'h0000_0000, 3'd2, 0, 1, 32'hdead_beef);
        run_txn(1'b1, 32'h1fd0_0010, 4'b0011, 32'h0000_abcd, 3'd1, 3, 0, 32'h0000_0000);
        reset_in_rd_wait();

        for (int i = 0; i < 80; i++) begin
            logic [31:0] sel_rand;
            sel_rand = $urandom;
            run_txn(sel_rand[0], $urandom, sel_rand[7:4], $urandom, sel_rand[10:8],
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom);
        end

        idle_inputs();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_uncached_port.md
DCACHE_UNCACHED_PORT -- requirements
Module: dcache_uncached_port

Interface
REQ-001 The block SHALL have these ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 The block SHALL have these request ports from the memory stage:
- req_ce  in  1  request valid
- req_we  in  1  store when 1, load when 0
- req_addr  in  32  physical address
- req_sel  in  4  byte enables
- req_data  in  32  store data, already lane-aligned
- req_rd_type  in  3  load size
- req_wr_type  in  3  store size
REQ-003 The block SHALL have these response ports to the memory stage:
- ready_o  out  1  can accept a request this cycle
- ack_o  out  1  request completed, one-cycle pulse
- rdata_o  out  32  load data, valid with ack_o on loads
REQ-004 The block SHALL have these bus read ports: bus_rd_req  out  1; bus_rd_type  out  3; bus_rd_addr  out  32; bus_rd_rdy  in  1; bus_ret_valid  in  1; bus_ret_data  in  32.
REQ-005 The block SHALL have these bus write ports: bus_wr_req  out  1; bus_wr_type  out  3; bus_wr_addr  out  32; bus_wr_strb  out  4; bus_wr_data  out  32; bus_wr_rdy  in  1.

Function
REQ-006 The FSM SHALL have exactly these states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
REQ-007 ready_o SHALL be 1 only in IDLE, and also requires the write buffer to be empty when WBUF is compiled in.
REQ-008 A request SHALL be accepted in the cycle where req_ce && ready_o; all req_* fields are registered that cycle, and req_* in other cycles are ignored.
REQ-009 An accepted load SHALL go IDLE->RD_REQ; an accepted store SHALL go IDLE->WR_REQ, except as modified by REQ-016.
REQ-010 In RD_REQ, bus_rd_req SHALL be held at 1 with registered addr/rd_type until bus_rd_rdy=1, then the FSM goes to RD_WAIT.
REQ-011 In RD_WAIT, when bus_ret_valid=1, bus_ret_data SHALL be captured into rdata_o and the FSM goes to RESP.
REQ-012 In WR_REQ, bus_wr_req SHALL be held at 1 with registered addr/strb(=sel)/data/wr_type until bus_wr_rdy=1, then the FSM goes to RESP.
REQ-013 In RESP, ack_o SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-014 rdata_o SHALL hold its last captured value until the next load capture.
REQ-015 Minimum latency SHALL be: load acceptance at T, rdy at T+1, ret_valid at T+2 -> ack at T+3; store acceptance at T, rdy at T+1 -> ack at T+2.
REQ-016 With WBUF enabled, a store accepted at T SHALL be placed in a 1-entry write buffer; the FSM goes to RESP (ack at T+1), and the buffer drains via bus_wr_req independently until bus_wr_rdy.
REQ-017 Bus outputs SHALL change only on state transitions, never combinationally from bus_*_rdy.
REQ-018 When bus_rd_rdy and bus_ret_valid are both 1 in RD_REQ, bus_ret_valid SHALL be ignored; only RD_WAIT samples return data.

Reset
REQ-019 On rst, the block SHALL set: state=IDLE, ready_o=1, ack_o=0, rdata_o=0, bus_rd_req=0, bus_wr_req=0, all bus address/data/strb/type=0, write buffer empty.
REQ-020 rst asserted mid-transaction SHALL abandon it without ack_o; the next cycle after rst deasserts, the block SHALL be in IDLE.

Configuration
REQ-021 Macro DCACHE_UNCACHED_WBUF_EN SHALL control the write buffer: defined -> 1-entry posted-write buffer per REQ-016; undefined -> stores block in WR_REQ until bus_wr_rdy, with no buffer logic.

Verification
REQ-022 Load: addr 0x1fd0_0004, rdy at T+1, ret_valid with data 0xdead_beef at T+3 -> ack_o and rdata_o=0xdead_beef at T+4, with ready_o=1 at T+5.
REQ-023 Store sel=0011 data=0x0000_abcd, bus_wr_rdy low 3 cycles -> bus_wr_req held 4 cycles with stable fields; ack one cycle after rdy (WBUF off).
REQ-024 WBUF on: store at T -> ack at T+1; ready_o=0 until bus_wr_rdy handshake; a load presented meanwhile is not accepted.
REQ-025 req_ce asserted in RD_WAIT -> request ignored, bus outputs unchanged, no extra ack.
REQ-026 rst asserted in RD_WAIT -> no ack; after rst, state IDLE, bus_rd_req=0, and a late bus_ret_valid is ignored.
